// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the FP add/subtract unit.
//   fpu_op_e       : operation encoding from the control unit
//   addsub_state_e : sequencing states of the multi-cycle adder
//   CANON_NAN      : quiet NaN returned for every invalid/NaN result
//   EXP_BIAS       : binary32 exponent bias
//   EXP_MAX        : all-ones biased exponent (inf / NaN)
// -----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [1:0] {
        FPU_ADD = 2'b00,
        FPU_SUB = 2'b01
    } fpu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADDM,
        S_NORM,
        S_ROUND
    } addsub_state_e;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam int          EXP_BIAS  = 127;
    localparam int          EXP_MAX   = 255;

endpackage

// File: rtl/fpu_lzc.sv
// -----------------------------------------------------------------------------
// fpu_lzc
// Combinational leading-zero counter.
//   data_i  : word to scan, MSB first
//   count_o : number of zeros above the highest set bit (WIDTH when data_i==0)
// -----------------------------------------------------------------------------
module fpu_lzc #(
    parameter int WIDTH = 28,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] count_o
);

    // Scanning upward lets the highest set bit overwrite any lower one.
    always_comb begin
        count_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                count_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_mc.sv
// -----------------------------------------------------------------------------
// fpu_addsub_mc
// Multi-cycle binary32 add/subtract, round-to-nearest-even, no denormals.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   valid_i / ready_o  : request handshake, accepted when both are high
//   fpu_op_i           : 00 add, 01 sub, 1x unsupported (returns invalid NaN)
//   op_a_i, op_b_i     : packed binary32 operands
//   valid_o            : one-cycle pulse when result_o / exc_o are new
//   result_o, exc_o    : result and {invalid, overflow, inexact}, held
// Sequence IDLE -> ALIGN -> ADDM -> NORM -> ROUND, one cycle each, sharing a
// single working register set.
// -----------------------------------------------------------------------------
module fpu_addsub_mc
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  fpu_op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [2:0]  exc_o
);

    // Working significand: hidden bit, fraction, guard, round, sticky.
    localparam int FW  = MAN_W + 4;
    localparam int SW  = FW + 1;
    localparam int LZW = $clog2(SW + 1);
    localparam int MW  = EXP_W + MAN_W;

    addsub_state_e   state_q, state_d;
    logic            ready_q, ready_d, valid_q, valid_d;
    logic [31:0]     result_q, result_d;
    logic [2:0]      exc_q, exc_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic            sign_q, sign_d, sub_q, sub_d;
    logic [EXP_W+1:0] exp_q, exp_d;
    logic [SW-1:0]   mant_q, mant_d;
    logic [FW-1:0]   mant_b_q, mant_b_d;
    logic            special_q, special_d, spec_inv_q, spec_inv_d, uflow_q, uflow_d;
    logic [31:0]     spec_res_q, spec_res_d;

    // ---------------- ALIGN datapath ----------------
    logic             b_sign_eff, a_max, b_max, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    logic [MW-1:0]    mag_a, mag_b, mag_l, mag_s;
    logic             swap, sign_l, sign_s;
    logic [MAN_W:0]   sig_l, sig_s;
    logic [EXP_W-1:0] exp_diff, shift_amt;
    logic [2*FW-1:0]  shift_wide;
    logic [FW-1:0]    aligned_s;
    logic             is_special, special_inv;
    logic [31:0]      special_res;

    assign b_sign_eff = b_q[31] ^ (op_q == FPU_SUB);
    assign a_max  = &a_q[MW-1:MAN_W];
    assign b_max  = &b_q[MW-1:MAN_W];
    assign a_nan  = a_max & (|a_q[MAN_W-1:0]);
    assign b_nan  = b_max & (|b_q[MAN_W-1:0]);
    assign a_snan = a_nan & ~a_q[MAN_W-1];
    assign b_snan = b_nan & ~b_q[MAN_W-1];
    assign a_inf  = a_max & ~(|a_q[MAN_W-1:0]);
    assign b_inf  = b_max & ~(|b_q[MAN_W-1:0]);

    // Zero exponent (zero or denormal) is flushed to a zero magnitude.
    assign mag_a  = (a_q[MW-1:MAN_W] == '0) ? '0 : a_q[MW-1:0];
    assign mag_b  = (b_q[MW-1:MAN_W] == '0) ? '0 : b_q[MW-1:0];
    assign swap   = mag_b > mag_a;
    assign mag_l  = swap ? mag_b : mag_a;
    assign mag_s  = swap ? mag_a : mag_b;
    assign sign_l = swap ? b_sign_eff : a_q[31];
    assign sign_s = swap ? a_q[31] : b_sign_eff;
    assign sig_l  = {|mag_l[MW-1:MAN_W], mag_l[MAN_W-1:0]};
    assign sig_s  = {|mag_s[MW-1:MAN_W], mag_s[MAN_W-1:0]};

    // Shift through a double-width window: the lower half collects every bit
    // that falls off the working field and is folded into the sticky bit.
    assign exp_diff   = mag_l[MW-1:MAN_W] - mag_s[MW-1:MAN_W];
    assign shift_amt  = (exp_diff >= EXP_W'(FW)) ? EXP_W'(FW) : exp_diff;
    assign shift_wide = {sig_s, 3'b000, {FW{1'b0}}} >> shift_amt;
    assign aligned_s  = {shift_wide[2*FW-1:FW+1], shift_wide[FW] | (|shift_wide[FW-1:0])};

    // Special operands decide the result now; ROUND just forwards it.
    always_comb begin
        is_special  = 1'b1;
        special_inv = 1'b0;
        special_res = CANON_NAN;
        if (op_q[1]) begin
            special_inv = 1'b1;
        end else if (a_nan || b_nan) begin
            special_inv = a_snan | b_snan;
        end else if (a_inf && b_inf && (a_q[31] != b_sign_eff)) begin
            special_inv = 1'b1;
        end else if (a_inf) begin
            special_res = {a_q[31], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            special_res = {b_sign_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    // ---------------- ADDM / NORM / ROUND datapath ----------------
    logic [SW-1:0]           sum;
    logic [LZW-1:0]          lz, norm_shift;
    logic signed [EXP_W+2:0] norm_exp;
    logic                    round_up, inexact;
    logic [MAN_W+1:0]        rounded;
    logic [EXP_W+1:0]        exp_r;
    logic [MAN_W-1:0]        frac_r;

    assign sum = sub_q ? (mant_q - {1'b0, mant_b_q}) : (mant_q + {1'b0, mant_b_q});

    fpu_lzc #(.WIDTH(SW), .CNT_W(LZW)) u_lzc (
        .data_i  (mant_q),
        .count_o (lz)
    );

    // Hidden bit sits one below the carry position, hence the -1.
    assign norm_shift = lz - LZW'(1);
    assign norm_exp   = $signed({1'b0, exp_q}) - $signed({{(EXP_W+3-LZW){1'b0}}, norm_shift});

    assign round_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    assign inexact  = |mant_q[2:0];
    assign rounded  = {1'b0, mant_q[FW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    assign exp_r    = exp_q + {{(EXP_W+1){1'b0}}, rounded[MAN_W+1]};
    assign frac_r   = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

    // Next-state and datapath register updates for every state.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        valid_d    = 1'b0;
        result_d   = result_q;
        exc_d      = exc_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        mant_b_d   = mant_b_q;
        special_d  = special_q;
        spec_inv_d = spec_inv_q;
        spec_res_d = spec_res_q;
        uflow_d    = uflow_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_q) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    op_d    = fpu_op_i;
                    ready_d = 1'b0;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                sign_d     = sign_l;
                sub_d      = sign_l ^ sign_s;
                exp_d      = {2'b00, mag_l[MW-1:MAN_W]};
                mant_d     = {1'b0, sig_l, 3'b000};
                mant_b_d   = aligned_s;
                special_d  = is_special;
                spec_inv_d = special_inv;
                spec_res_d = special_res;
                uflow_d    = 1'b0;
                state_d    = S_ADDM;
            end
            S_ADDM: begin
                mant_d = sum;
                // Exact cancellation of opposite signs yields +0.
                if (sub_q && (sum == '0)) begin
                    sign_d = 1'b0;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (mant_q[SW-1]) begin
                    mant_d = {1'b0, mant_q[SW-1:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 1'b1;
                end else if (mant_q == '0) begin
                    exp_d = '0;
                end else if (norm_exp[EXP_W+2] || (norm_exp == '0)) begin
                    exp_d   = '0;
                    mant_d  = '0;
                    uflow_d = 1'b1;
                end else begin
                    mant_d = mant_q << norm_shift;
                    exp_d  = norm_exp[EXP_W+1:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (special_q) begin
                    result_d = spec_res_q;
                    exc_d    = {spec_inv_q, 2'b00};
                end else if (exp_q == '0) begin
                    result_d = {sign_q, 31'b0};
                    exc_d    = {2'b00, uflow_q};
                end else if (exp_r >= (EXP_W+2)'(EXP_MAX)) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    exc_d    = 3'b011;
                end else begin
                    result_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
                    exc_d    = {2'b00, inexact};
                end
                valid_d = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Single register bank; reset discards any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            result_q   <= '0;
            exc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            mant_b_q   <= '0;
            special_q  <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_res_q <= '0;
            uflow_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            exc_q      <= exc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            mant_b_q   <= mant_b_d;
            special_q  <= special_d;
            spec_inv_q <= spec_inv_d;
            spec_res_q <= spec_res_d;
            uflow_q    <= uflow_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign exc_o    = exc_q;

endmodule

// File: tb/tb_fpu_addsub_mc.sv
// -----------------------------------------------------------------------------
// tb_fpu_addsub_mc
// Directed vectors for fpu_addsub_mc. The driver pushes the hand-computed
// result into a scoreboard on every accepted request; an independent monitor
// pops and compares whenever valid_o pulses, including the accept-to-valid
// latency.
// -----------------------------------------------------------------------------
module tb_fpu_addsub_mc;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  fpu_op_i = 2'b00;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        valid_o;
    logic [31:0] result_o;
    logic [2:0]  exc_o;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  exc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   issued = 0;
    int   seen = 0;

    fpu_addsub_mc dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .fpu_op_i (fpu_op_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .valid_o  (valid_o),
        .result_o (result_o),
        .exc_o    (exc_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every valid_o pulse must match the oldest outstanding request.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o) begin
            seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got result %h exc %b, expected no output", result_o, exc_o);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("result", result_o, mon_e.res);
                checkOutput("exc", {29'b0, exc_o}, {29'b0, mon_e.exc});
                checkOutput("latency", 32'(cycle - mon_e.cyc), 32'd4);
            end
        end
    end

    // Issue one request once the unit is idle and record what it must return.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] er, input logic [2:0] ee);
        int w;
        w = 0;
        @(negedge clk_i);
        while (!ready_o && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        checkOutput("ready_idle", 32'(ready_o), 32'd1);
        if (ready_o) begin
            fpu_op_i = op;
            op_a_i   = a;
            op_b_i   = b;
            valid_i  = 1'b1;
            @(posedge clk_i);
            #1;
            valid_i = 1'b0;
            sb.push_back('{er, ee, cycle});
            issued++;
            checkOutput("ready_busy", 32'(ready_o), 32'd0);
        end
    endtask

    initial begin
        int w;
        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_result", result_o, 32'h0);
        checkOutput("rst_exc", {29'b0, exc_o}, 32'h0);
        rst_ni = 1'b1;

        // Directed vectors: op, A, B, expected result, expected {invalid, overflow, inexact}
        applyStimulus(2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
        applyStimulus(2'b01, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 3'b000);
        applyStimulus(2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b001);
        applyStimulus(2'b00, 32'h33800000, 32'h3F800000, 32'h3F800000, 3'b001);
        applyStimulus(2'b00, 32'h3F800001, 32'h33800000, 32'h3F800002, 3'b001);
        applyStimulus(2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b011);
        applyStimulus(2'b00, 32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 3'b011);
        applyStimulus(2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100);
        applyStimulus(2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h7FC00000, 3'b100);
        applyStimulus(2'b00, 32'h40400000, 32'hBF800000, 32'h40000000, 3'b000);
        applyStimulus(2'b00, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b000);
        applyStimulus(2'b00, 32'h7F800001, 32'h00000000, 32'h7FC00000, 3'b100);
        applyStimulus(2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000);
        applyStimulus(2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000);
        applyStimulus(2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000);
        applyStimulus(2'b00, 32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000);
        applyStimulus(2'b01, 32'h00800001, 32'h00800000, 32'h00000000, 3'b001);
        applyStimulus(2'b01, 32'h3F800001, 32'h3F800000, 32'h34000000, 3'b000);
        applyStimulus(2'b01, 32'h3F800000, 32'h00800000, 32'h3F800000, 3'b001);

        // valid_i held high through the busy period with new operands
        @(negedge clk_i);
        w = 0;
        while (!ready_o && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        checkOutput("ready_before_hold", 32'(ready_o), 32'd1);
        fpu_op_i = 2'b00;
        op_a_i   = 32'h3F800000;
        op_b_i   = 32'h3F800000;
        valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        sb.push_back('{32'h40000000, 3'b000, cycle});
        issued++;
        op_a_i = 32'h40400000;
        op_b_i = 32'h40400000;
        repeat (4) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (8) @(posedge clk_i);

        // Reset while the operation sits in NORM: it must vanish
        @(negedge clk_i);
        fpu_op_i = 2'b00;
        op_a_i   = 32'h3F800000;
        op_b_i   = 32'h3F800000;
        valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("midrst_ready", 32'(ready_o), 32'd1);
        checkOutput("midrst_valid", 32'(valid_o), 32'd0);
        checkOutput("midrst_result", result_o, 32'h0);
        checkOutput("midrst_exc", {29'b0, exc_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (8) @(posedge clk_i);

        // Recovery after reset
        applyStimulus(2'b00, 32'h40400000, 32'hBF800000, 32'h40000000, 3'b000);

        // Drain the scoreboard within a bounded window
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(posedge clk_i);
            w++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
        repeat (10) @(posedge clk_i);
        checkOutput("out_count", 32'(seen), 32'(issued));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
